mcs4_timing_gen: RTL and testbench

//   Instruction-cycle timing generator for the MCS-4 core; sits directly downstream of the two-phase clock generator.

---
 rtl/mcs4_pkg.sv | 25 ++
 rtl/mcs4_phase_det.sv | 36 +++
 rtl/mcs4_timing_gen.sv | 138 +++++++++++++
 tb/tb_mcs4_timing_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs4_pkg.sv
// mcs4_pkg
//   Shared definitions for the MCS-4 instruction-cycle timing generator:
//   subcycle encoding, PHI timing constants and the subcycle successor.
package mcs4_pkg;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } subcycle_e;

    localparam int PHI_PERIOD = 7;
    localparam int SUBCYCLES  = 8;

    // X3 + 1 wraps to A1 in three bits, so the encoding itself gives the order.
    function automatic subcycle_e next_cycle(input subcycle_e c);
        return subcycle_e'(3'(c + 3'd1));
    endfunction

endpackage

// File: rtl/mcs4_phase_det.sv
// mcs4_phase_det
//   Watches the active-low two-phase clock pair coming from the clock
//   generator. Produces a one-clk advance pulse at the end of every PHI2 low
//   pulse and flags PHI1/PHI2 overlap.
// Ports
//   clk_i    in   main clock
//   rst_ni   in   async active-low reset
//   PHI1_i   in   phase-1 clock, active low
//   PHI2_i   in   phase-2 clock, active low
//   advance  out  1 while PHI2_i is high and was low on the previous clk
//   overlap  out  1 while PHI1_i and PHI2_i are both low
module mcs4_phase_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic PHI1_i,
    input  logic PHI2_i,
    output logic advance,
    output logic overlap
);

    logic phi2_q;

    // Reset to high so a PHI2 that is already high at reset release does not
    // look like a rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phi2_q <= 1'b1;
        end else begin
            phi2_q <= PHI2_i;
        end
    end

    assign advance = PHI2_i & ~phi2_q;
    assign overlap = ~PHI1_i & ~PHI2_i;

endmodule

// File: rtl/mcs4_timing_gen.sv
// mcs4_timing_gen
//   Instruction-cycle timing generator for the MCS-4 core. Steps through the
//   eight subcycles once per PHI2 pulse and drives SYNC, the subcycle code,
//   step/instruction strobes and an instruction-cycle counter.
//   Optional feature macro: MCS4_SYNC_SLAVE_EN -- adds SYNC_i; an external
//   SYNC low at an advance forces the next subcycle to A1.
// Ports
//   clk_i       in   main clock
//   rst_ni      in   async active-low reset
//   PHI1_i      in   phase-1 clock, active low (overlap check only)
//   PHI2_i      in   phase-2 clock, active low (stepping)
//   SYNC_i      in   external SYNC, active low (MCS4_SYNC_SLAVE_EN only)
//   SYNC_o      out  active-low SYNC, low for the whole of X3
//   cycle_o     out  current subcycle code
//   valid_o     out  1 once the first subcycle has started after reset
//   step_o      out  1-clk pulse on every subcycle advance
//   inst_stb_o  out  1-clk pulse on entry to A1
//   icnt_o      out  count of A1 entries after the first one
//   err_o       out  sticky PHI overlap / SYNC misalignment flag
//
// State | meaning
// A1    | address phase 1 (instruction cycle start)
// A2    | address phase 2
// A3    | address phase 3
// M1    | memory phase 1
// M2    | memory phase 2
// X1    | execute phase 1
// X2    | execute phase 2
// X3    | execute phase 3, SYNC low; also the idle state after reset
module mcs4_timing_gen
    import mcs4_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             PHI1_i,
    input  logic             PHI2_i,
`ifdef MCS4_SYNC_SLAVE_EN
    input  logic             SYNC_i,
`endif
    output logic             SYNC_o,
    output logic [2:0]       cycle_o,
    output logic             valid_o,
    output logic             step_o,
    output logic             inst_stb_o,
    output logic [CNT_W-1:0] icnt_o,
    output logic             err_o
);

    logic             advance;
    logic             overlap;

    subcycle_e        cycle_q, cycle_d;
    logic             valid_d;
    logic             step_d;
    logic             stb_d;
    logic [CNT_W-1:0] icnt_d;
    logic             err_d;
    logic             sync_d;

    mcs4_phase_det u_phase_det (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .PHI1_i  (PHI1_i),
        .PHI2_i  (PHI2_i),
        .advance (advance),
        .overlap (overlap)
    );

`ifdef MCS4_SYNC_SLAVE_EN
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= SYNC_i;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q    <= X3;
            valid_o    <= 1'b0;
            SYNC_o     <= 1'b1;
            step_o     <= 1'b0;
            inst_stb_o <= 1'b0;
            icnt_o     <= '0;
            err_o      <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            valid_o    <= valid_d;
            SYNC_o     <= sync_d;
            step_o     <= step_d;
            inst_stb_o <= stb_d;
            icnt_o     <= icnt_d;
            err_o      <= err_d;
        end
    end

    always_comb begin
        cycle_d = cycle_q;
        valid_d = valid_o;
        step_d  = 1'b0;
        stb_d   = 1'b0;
        icnt_d  = icnt_o;
        err_d   = err_o | overlap;

        if (advance) begin
            cycle_d = next_cycle(cycle_q);
`ifdef MCS4_SYNC_SLAVE_EN
            if (!sync_q) begin
                cycle_d = A1;
                if (cycle_q != X3) begin
                    err_d = 1'b1;
                end
            end
`endif
            valid_d = 1'b1;
            step_d  = 1'b1;
            if (cycle_d == A1) begin
                stb_d = 1'b1;
                // The X3->A1 move out of reset starts the first cycle; it is
                // not a completed one, so it is not counted.
                if (valid_o) begin
                    icnt_d = icnt_o + CNT_W'(1);
                end
            end
        end

        sync_d = ~(valid_d && (cycle_d == X3));
    end

    assign cycle_o = cycle_q;

endmodule

// File: tb/tb_mcs4_timing_gen.sv
module tb_mcs4_timing_gen;
    import mcs4_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        phi1;
    logic        phi2;
    logic        sync_in;
    logic        sync_o,  sync4;
    logic [2:0]  cycle_o, cycle4;
    logic        valid_o, valid4;
    logic        step_o,  step4;
    logic        stb_o,   stb4;
    logic [15:0] icnt_o;
    logic [3:0]  icnt4;
    logic        err_o,   err4;

    bit gen_run;
    bit ovl;
    int ph;

    int n_tests;
    int n_fail;

    mcs4_timing_gen #(.CNT_W(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .PHI1_i     (phi1),
        .PHI2_i     (phi2),
`ifdef MCS4_SYNC_SLAVE_EN
        .SYNC_i     (sync_in),
`endif
        .SYNC_o     (sync_o),
        .cycle_o    (cycle_o),
        .valid_o    (valid_o),
        .step_o     (step_o),
        .inst_stb_o (stb_o),
        .icnt_o     (icnt_o),
        .err_o      (err_o)
    );

    mcs4_timing_gen #(.CNT_W(4)) dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .PHI1_i     (phi1),
        .PHI2_i     (phi2),
`ifdef MCS4_SYNC_SLAVE_EN
        .SYNC_i     (sync_in),
`endif
        .SYNC_o     (sync4),
        .cycle_o    (cycle4),
        .valid_o    (valid4),
        .step_o     (step4),
        .inst_stb_o (stb4),
        .icnt_o     (icnt4),
        .err_o      (err4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-phase clock model: 7-clk period, PHI1 low for phases 0-1,
    // PHI2 low for phases 3-4, changing on the falling clk edge.
    initial begin
        ph   = 0;
        phi1 = 1'b1;
        phi2 = 1'b1;
        forever begin
            @(negedge clk);
            if (gen_run) ph = (ph == 6) ? 0 : ph + 1;
            if (ovl) begin
                phi1 = 1'b0;
                phi2 = 1'b0;
            end else if (gen_run) begin
                phi1 = !(ph <= 1);
                phi2 = !(ph == 3 || ph == 4);
            end else begin
                phi1 = 1'b1;
                phi2 = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_step(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (step_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (stb_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int steps, lows, stbs, gap_bad, last, timeouts;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        gen_run = 1'b1;
        ovl     = 1'b0;
        sync_in = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cycle", 32'(cycle_o), 32'(X3));
        check("rst_valid", 32'(valid_o), 0);
        check("rst_sync",  32'(sync_o),  1);
        check("rst_step",  32'(step_o),  0);
        check("rst_stb",   32'(stb_o),   0);
        check("rst_icnt",  32'(icnt_o),  0);
        check("rst_err",   32'(err_o),   0);

        // first advance after reset release
        rst_n = 1'b1;
        wait_step(ok);
        check("first_step_seen", 32'(ok), 1);
        check("first_cycle", 32'(cycle_o), 32'(A1));
        check("first_stb",   32'(stb_o),   1);
        check("first_icnt",  32'(icnt_o),  0);
        check("first_valid", 32'(valid_o), 1);
        check("first_sync",  32'(sync_o),  1);

        // three instruction cycles counted from the first A1
        steps = 0; lows = 0; stbs = 0; gap_bad = 0; last = 0;
        for (int t = 1; t <= 167; t++) begin
            @(posedge clk);
            #1;
            if (step_o) begin
                steps++;
                if (t - last != PHI_PERIOD) gap_bad++;
                last = t;
            end
            if (!sync_o) lows++;
            if (stb_o) stbs++;
        end
        check("run_steps",   32'(steps),   23);
        check("run_gap_bad", 32'(gap_bad), 0);
        check("run_sync_lo", 32'(lows),    21);
        check("run_stbs",    32'(stbs),    2);
        check("run_icnt",    32'(icnt_o),  2);
        check("run_icnt4",   32'(icnt4),   2);
        check("run_cycle",   32'(cycle_o), 32'(X3));
        check("run_sync",    32'(sync_o),  0);

        // wrap of the 4-bit counter: entries 4..16, then entry 17
        timeouts = 0;
        for (int e = 4; e <= 16; e++) begin
            wait_stb(ok);
            if (!ok) timeouts++;
        end
        check("wrap_timeouts", 32'(timeouts), 0);
        check("wrap_icnt4_15", 32'(icnt4),  15);
        check("wrap_icnt_15",  32'(icnt_o), 15);
        wait_stb(ok);
        check("wrap_stb_seen", 32'(ok),      1);
        check("wrap_icnt4_0",  32'(icnt4),   0);
        check("wrap_icnt_16",  32'(icnt_o),  16);
        check("wrap_err4",     32'(err4),    0);
        check("wrap_err",      32'(err_o),   0);
        check("wrap_cycle",    32'(cycle_o), 32'(A1));

        // asynchronous reset while in M2
        timeouts = 0;
        repeat (4) begin
            wait_step(ok);
            if (!ok) timeouts++;
        end
        check("m2_timeouts", 32'(timeouts), 0);
        check("m2_cycle",    32'(cycle_o),  32'(M2));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cycle", 32'(cycle_o), 32'(X3));
        check("arst_sync",  32'(sync_o),  1);
        check("arst_valid", 32'(valid_o), 0);
        check("arst_step",  32'(step_o),  0);
        check("arst_stb",   32'(stb_o),   0);
        check("arst_icnt",  32'(icnt_o),  0);
        check("arst_icnt4", 32'(icnt4),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_step(ok);
        check("resume_seen",  32'(ok),      1);
        check("resume_cycle", 32'(cycle_o), 32'(A1));
        check("resume_stb",   32'(stb_o),   1);
        check("resume_icnt",  32'(icnt_o),  0);

        // PHI2 stuck high: no steps, no strobes
        gen_run = 1'b0;
        repeat (3) @(posedge clk);
        steps = 0; stbs = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (step_o) steps++;
            if (stb_o) stbs++;
        end
        check("stuck_steps", 32'(steps), 0);
        check("stuck_stbs",  32'(stbs),  0);

        // one clk of PHI1/PHI2 overlap
        check("ovl_err_before", 32'(err_o), 0);
        ovl = 1'b1;
        @(posedge clk);
        #1;
        ovl = 1'b0;
        check("ovl_err_set",  32'(err_o), 1);
        check("ovl_err4_set", 32'(err4),  1);
        repeat (20) @(posedge clk);
        #1;
        check("ovl_err_held", 32'(err_o), 1);
        rst_n = 1'b0;
        #1;
        check("ovl_err_rst", 32'(err_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovl_err_after", 32'(err_o), 0);

`ifdef MCS4_SYNC_SLAVE_EN
        // external SYNC low at the A3 advance forces A1 and flags misalignment
        gen_run = 1'b1;
        wait_step(ok);
        check("slv_first_seen", 32'(ok), 1);
        check("slv_first_cyc",  32'(cycle_o), 32'(A1));
        wait_step(ok);
        wait_step(ok);
        check("slv_a3_cycle", 32'(cycle_o), 32'(A3));
        check("slv_err_pre",  32'(err_o),   0);
        sync_in = 1'b0;
        wait_step(ok);
        sync_in = 1'b1;
        check("slv_step_seen", 32'(ok),      1);
        check("slv_cycle",     32'(cycle_o), 32'(A1));
        check("slv_stb",       32'(stb_o),   1);
        check("slv_err",       32'(err_o),   1);
        check("slv_icnt",      32'(icnt_o),  1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
